// File: rtl/efx_clk_freq_checker.sv
// Qualifies per-window inclk frequency counts against EXP_FREQ +/- TOL_FREQ,
// debounces the result into a lock FSM, counts lock losses and flags a stale monitor.
module efx_clk_freq_checker #(
    parameter int unsigned EXP_FREQ   = 100000000,
    parameter int unsigned TOL_FREQ   = 100000,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 2,
    parameter int unsigned TIMEOUT    = 200000000
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        meas_valid,
    input  logic [28:0] meas_freq,
    output logic        freq_ok,
    output logic        freq_lo,
    output logic        freq_hi,
    output logic        stale,
    output logic [1:0]  state,
    output logic [28:0] last_freq,
    output logic [15:0] loss_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACQ    = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [1:0] S_LOST   = 2'd3;

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam int IW = $clog2(TIMEOUT);

    localparam logic [GW-1:0] LOCK_N   = GW'(LOCK_CNT);
    localparam logic [BW-1:0] UNLOCK_N = BW'(UNLOCK_CNT);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

    // Window bounds held in 30 bits so EXP+TOL cannot wrap and EXP<TOL clamps to 0.
    localparam logic [29:0] EXP30    = 30'(EXP_FREQ);
    localparam logic [29:0] TOL30    = 30'(TOL_FREQ);
    localparam logic [29:0] LO_BOUND = (EXP30 > TOL30) ? (EXP30 - TOL30) : 30'd0;
    localparam logic [29:0] HI_BOUND = EXP30 + TOL30;

    function automatic logic [GW-1:0] good_inc(input logic [GW-1:0] x);
        return (x >= LOCK_N) ? LOCK_N : x + 1'b1;
    endfunction

    function automatic logic [BW-1:0] bad_inc(input logic [BW-1:0] x);
        return (x >= UNLOCK_N) ? UNLOCK_N : x + 1'b1;
    endfunction

    function automatic logic [15:0] loss_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    logic [1:0]    state_q, state_d;
    logic          ok_q, ok_d;
    logic          lo_q, lo_d;
    logic          hi_q, hi_d;
    logic          stale_q, stale_d;
    logic [28:0]   last_q, last_d;
    logic [15:0]   loss_q, loss_d;
    logic [GW-1:0] good_q, good_d;
    logic [BW-1:0] bad_q, bad_d;
    logic [IW-1:0] idle_q, idle_d;

    logic          below, above, good;
    logic [GW-1:0] good_nxt;
    logic [BW-1:0] bad_nxt;

    always_comb begin
        below    = {1'b0, meas_freq} < LO_BOUND;
        above    = {1'b0, meas_freq} > HI_BOUND;
        good     = !below && !above;
        good_nxt = good_inc(good_q);
        bad_nxt  = bad_inc(bad_q);

        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        stale_d = stale_q;
        last_d  = last_q;
        loss_d  = loss_q;
        good_d  = good_q;
        bad_d   = bad_q;
        idle_d  = idle_q;

        if (meas_valid) begin
            idle_d  = '0;
            stale_d = 1'b0;
            lo_d    = below;
            hi_d    = above;
            last_d  = meas_freq;
            case (state_q)
                S_IDLE, S_LOST: begin
                    if (good) begin
                        good_d  = GW'(1);
                        bad_d   = '0;
                        state_d = (LOCK_CNT == 1) ? S_LOCKED : S_ACQ;
                    end
                end
                S_ACQ: begin
                    if (good) begin
                        good_d = good_nxt;
                        if (good_nxt >= LOCK_N) begin
                            state_d = S_LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (good) begin
                        bad_d = '0;
                    end else begin
                        bad_d = bad_nxt;
                        if (bad_nxt >= UNLOCK_N) begin
                            state_d = S_LOST;
                            loss_d  = loss_inc(loss_q);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (idle_q == IDLE_MAX) begin
            // Monitor went silent: drop lock without counting it as a loss.
            stale_d = 1'b1;
            state_d = S_IDLE;
            good_d  = '0;
            bad_d   = '0;
        end else begin
            idle_d = idle_q + 1'b1;
        end

        ok_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ok_q    <= 1'b0;
            lo_q    <= 1'b0;
            hi_q    <= 1'b0;
            stale_q <= 1'b0;
            last_q  <= '0;
            loss_q  <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            ok_q    <= ok_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            stale_q <= stale_d;
            last_q  <= last_d;
            loss_q  <= loss_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            idle_q  <= idle_d;
        end
    end

    assign freq_ok   = ok_q;
    assign freq_lo   = lo_q;
    assign freq_hi   = hi_q;
    assign stale     = stale_q;
    assign state     = state_q;
    assign last_freq = last_q;
    assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_efx_clk_freq_checker.sv
// Bench for efx_clk_freq_checker: scoreboarded strobes on a 100 MHz-window instance,
// plus a second instance whose tolerance exceeds the expected frequency.
module tb_efx_clk_freq_checker;

    localparam int unsigned EXP  = 100000000;
    localparam int unsigned TOL  = 100000;
    localparam int unsigned LOCK = 3;
    localparam int unsigned UNL  = 2;
    localparam int unsigned TMO  = 16;

    logic        refclk = 1'b0;
    logic        rst;
    logic        meas_valid;
    logic [28:0] meas_freq;
    logic        freq_ok, freq_lo, freq_hi, stale;
    logic [1:0]  state;
    logic [28:0] last_freq;
    logic [15:0] loss_cnt;

    logic        v2;
    logic [28:0] f2;
    logic        ok2, lo2, hi2, stale2;
    logic [1:0]  st2;
    logic [28:0] last2;
    logic [15:0] loss2;

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    efx_clk_freq_checker #(
        .EXP_FREQ(EXP), .TOL_FREQ(TOL), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNL), .TIMEOUT(TMO)
    ) dut (
        .refclk(refclk), .rst(rst), .meas_valid(meas_valid), .meas_freq(meas_freq),
        .freq_ok(freq_ok), .freq_lo(freq_lo), .freq_hi(freq_hi), .stale(stale),
        .state(state), .last_freq(last_freq), .loss_cnt(loss_cnt)
    );

    efx_clk_freq_checker #(
        .EXP_FREQ(50000), .TOL_FREQ(100000), .LOCK_CNT(1), .UNLOCK_CNT(1), .TIMEOUT(100000)
    ) dut_clamp (
        .refclk(refclk), .rst(rst), .meas_valid(v2), .meas_freq(f2),
        .freq_ok(ok2), .freq_lo(lo2), .freq_hi(hi2), .stale(stale2),
        .state(st2), .last_freq(last2), .loss_cnt(loss2)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        ok;
        logic        lo;
        logic        hi;
        logic        stl;
        logic [28:0] last;
        logic [15:0] loss;
    } exp_t;

    exp_t sb_q[$];

    // Reference model of the lock FSM, advanced once per strobe.
    int          m_state, m_good, m_bad;
    logic [15:0] m_loss;
    logic        m_lo, m_hi;
    logic [28:0] m_last;

    task automatic model_reset();
        m_state = 0; m_good = 0; m_bad = 0; m_loss = 16'd0;
        m_lo = 1'b0; m_hi = 1'b0; m_last = 29'd0;
    endtask

    task automatic model_step(input logic [28:0] f);
        exp_t e;
        longint fl;
        bit g;
        fl = longint'(f);
        m_lo = (fl < longint'(EXP - TOL));
        m_hi = (fl > longint'(EXP + TOL));
        g = !m_lo && !m_hi;
        m_last = f;
        case (m_state)
            0, 3: if (g) begin m_good = 1; m_bad = 0; m_state = (LOCK == 1) ? 2 : 1; end
            1: begin
                if (g) begin
                    m_good++;
                    if (m_good >= LOCK) begin m_state = 2; m_bad = 0; end
                end else m_good = 0;
            end
            default: begin
                if (g) m_bad = 0;
                else begin
                    m_bad++;
                    if (m_bad >= UNL) begin
                        m_state = 3;
                        if (m_loss != 16'hFFFF) m_loss = m_loss + 16'd1;
                    end
                end
            end
        endcase
        e.st = 2'(m_state); e.ok = (m_state == 2); e.lo = m_lo; e.hi = m_hi;
        e.stl = 1'b0; e.last = m_last; e.loss = m_loss;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic strobe(input logic [28:0] f, input string tag);
        exp_t e;
        meas_valid = 1'b1;
        meas_freq  = f;
        model_step(f);
        @(posedge refclk);
        #1;
        meas_valid = 1'b0;
        e = sb_q.pop_front();
        checks++; if (state !== e.st) begin errors++; $display("FAIL %s state got %0d exp %0d", tag, state, e.st); end
        checks++; if (freq_ok !== e.ok) begin errors++; $display("FAIL %s freq_ok got %0b exp %0b", tag, freq_ok, e.ok); end
        checks++; if (freq_lo !== e.lo) begin errors++; $display("FAIL %s freq_lo got %0b exp %0b", tag, freq_lo, e.lo); end
        checks++; if (freq_hi !== e.hi) begin errors++; $display("FAIL %s freq_hi got %0b exp %0b", tag, freq_hi, e.hi); end
        checks++; if (stale !== e.stl) begin errors++; $display("FAIL %s stale got %0b exp %0b", tag, stale, e.stl); end
        checks++; if (last_freq !== e.last) begin errors++; $display("FAIL %s last_freq got %0d exp %0d", tag, last_freq, e.last); end
        checks++; if (loss_cnt !== e.loss) begin errors++; $display("FAIL %s loss_cnt got %0d exp %0d", tag, loss_cnt, e.loss); end
    endtask

    task automatic test_reset();
        rst = 1'b1; meas_valid = 1'b0; meas_freq = 29'd0; v2 = 1'b0; f2 = 29'd0;
        idle(2);
        rst = 1'b0;
        model_reset();
        checks++; if ({state, freq_ok, freq_lo, freq_hi, stale} !== 6'd0) begin
            errors++; $display("FAIL reset_flags got %0h exp 0", {state, freq_ok, freq_lo, freq_hi, stale}); end
        checks++; if (last_freq !== 29'd0) begin errors++; $display("FAIL reset_last got %0d exp 0", last_freq); end
        checks++; if (loss_cnt !== 16'd0) begin errors++; $display("FAIL reset_loss got %0d exp 0", loss_cnt); end
        checks++; if ({st2, ok2, lo2, hi2, stale2, loss2} !== 22'd0) begin
            errors++; $display("FAIL reset_clamp got %0h exp 0", {st2, ok2, lo2, hi2, stale2, loss2}); end
    endtask

    task automatic test_lock();
        strobe(29'd100000000, "lock1");
        idle(1);
        strobe(29'd100000000, "lock2");
        strobe(29'd100000000, "lock3");
    endtask

    task automatic test_bounds();
        strobe(29'd99900000,  "bnd_lo_edge");
        strobe(29'd100100000, "bnd_hi_edge");
        strobe(29'd99899999,  "bnd_below");
        idle(3);
        checks++; if (freq_lo !== 1'b1) begin errors++; $display("FAIL hold_lo got %0b exp 1", freq_lo); end
        checks++; if (last_freq !== 29'd99899999) begin errors++; $display("FAIL hold_last got %0d exp 99899999", last_freq); end
        strobe(29'd100000000, "bnd_recover");
        strobe(29'd100100001, "bnd_above");
        strobe(29'd100000000, "bnd_recover2");
    endtask

    task automatic test_unlock();
        strobe(29'd1000,      "unl_bad1");
        strobe(29'd100000000, "unl_good");
        strobe(29'd200000000, "unl_bad2");
        strobe(29'd200000000, "unl_bad3");
    endtask

    task automatic test_acq_restart();
        strobe(29'd100000000, "acq_g1");
        strobe(29'd100000000, "acq_g2");
        strobe(29'd5,         "acq_bad");
        strobe(29'd100000000, "acq_g3");
        strobe(29'd100000000, "acq_g4");
        strobe(29'd100000000, "acq_g5");
    endtask

    task automatic test_timeout();
        idle(TMO - 1);
        strobe(29'd100000000, "tmo_race");
        idle(TMO - 1);
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL tmo_early got %0b exp 0", stale); end
        idle(1);
        checks++; if (stale !== 1'b1) begin errors++; $display("FAIL tmo_stale got %0b exp 1", stale); end
        checks++; if (state !== 2'd0 || freq_ok !== 1'b0) begin
            errors++; $display("FAIL tmo_state got %0d/%0b exp 0/0", state, freq_ok); end
        checks++; if (loss_cnt !== m_loss) begin errors++; $display("FAIL tmo_loss got %0d exp %0d", loss_cnt, m_loss); end
        m_state = 0; m_good = 0; m_bad = 0;
        idle(4);
        strobe(29'd100000000, "tmo_clear");
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; idle(1); rst = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++) strobe(29'd100000000, "b2b_good");
            strobe(29'd0, "b2b_bad");
            strobe(29'd0, "b2b_bad");
        end
        for (int j = 0; j < 3; j++) strobe(29'd100000000, "b2b_relock");
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; meas_valid = 1'b1; meas_freq = 29'd100000000;
        idle(1);
        rst = 1'b0; meas_valid = 1'b0;
        model_reset();
        checks++; if ({state, freq_ok, freq_lo, freq_hi, stale} !== 6'd0) begin
            errors++; $display("FAIL midrst_flags got %0h exp 0", {state, freq_ok, freq_lo, freq_hi, stale}); end
        checks++; if (last_freq !== 29'd0) begin errors++; $display("FAIL midrst_last got %0d exp 0", last_freq); end
        checks++; if (loss_cnt !== 16'd0) begin errors++; $display("FAIL midrst_loss got %0d exp 0", loss_cnt); end
    endtask

    task automatic test_clamp();
        v2 = 1'b1; f2 = 29'd0; idle(1); v2 = 1'b0;
        checks++; if ({st2, ok2, lo2, hi2} !== {2'd2, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL clamp_zero got %0h exp 8", {st2, ok2, lo2, hi2}); end
        v2 = 1'b1; f2 = 29'd150001; idle(1); v2 = 1'b0;
        checks++; if ({st2, ok2, lo2, hi2} !== {2'd3, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL clamp_above got %0h exp d", {st2, ok2, lo2, hi2}); end
        checks++; if (loss2 !== 16'd1) begin errors++; $display("FAIL clamp_loss got %0d exp 1", loss2); end
        v2 = 1'b1; f2 = 29'd150000; idle(1); v2 = 1'b0;
        checks++; if ({st2, ok2, lo2, hi2} !== {2'd2, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL clamp_edge got %0h exp 8", {st2, ok2, lo2, hi2}); end
        checks++; if (last2 !== 29'd150000) begin errors++; $display("FAIL clamp_last got %0d exp 150000", last2); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock();
        test_bounds();
        test_unlock();
        test_acq_restart();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        test_clamp();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
